// File: rtl/latch_ff_trio.sv
// latch_ff_trio: three independent storage elements fed from one data bus.
//   q_pos - flip-flop capturing d on the rising edge of clk
//   q_neg - flip-flop capturing d on the falling edge of clk
//   q_lat - level-sensitive latch, transparent while clk is high
// All three share only their inputs (clk, rst_n, en, d); none reads another's
// state. en gates every element: low means hold. rst_n is asynchronous and
// active low, forcing every output to zero immediately and for as long as it
// stays low. Bits are fully independent; WIDTH just replicates the slice.
// There is no handshake on this block: d and en are plain level inputs that
// are sampled at the active edge (flops) or continuously (latch).
module latch_ff_trio #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_pos,
    output logic [WIDTH-1:0] q_neg,
    output logic [WIDTH-1:0] q_lat
);

    // Rising-edge capture; the edge itself updates q_pos (no extra stage).
    // A release of rst_n in the same timestep as the edge does not capture,
    // because the edge sees rst_n still low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pos <= '0;
        end else if (en) begin
            q_pos <= d;
        end
    end

    // Falling-edge capture, mirror of the rising-edge element.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg <= '0;
        end else if (en) begin
            q_neg <= d;
        end
    end

    // Latch: follows d while clk and en are high, otherwise holds the last
    // value seen; when clk falls it therefore keeps the d present at the fall.
    always_latch begin
        if (!rst_n) begin
            q_lat <= '0;
        end else if (clk && en) begin
            q_lat <= d;
        end
    end

endmodule

// File: tb/tb_latch_ff_trio.sv
// Bench for latch_ff_trio at WIDTH=8: a timed waveform table, hand-written
// corner sequences (glitch, async reset, enable, width, reset release on an
// edge) and a randomized run against a half-period event model.
`timescale 1ns/1ps
module tb_latch_ff_trio;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] d;
    logic [W-1:0] q_pos;
    logic [W-1:0] q_neg;
    logic [W-1:0] q_lat;

    int tests = 0;
    int fails = 0;

    latch_ff_trio #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (d),
        .q_pos (q_pos),
        .q_neg (q_neg),
        .q_lat (q_lat)
    );

    // Clock: 20 ns period, low 0-10, rising at 10, 30, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk3(input string name, input logic [W-1:0] ep, input logic [W-1:0] en_v,
                        input logic [W-1:0] el);
        chk({name, ".q_pos"}, q_pos, ep);
        chk({name, ".q_neg"}, q_neg, en_v);
        chk({name, ".q_lat"}, q_lat, el);
    endtask

    // Waveform table: d events and sample points with expected 1-bit levels
    // (replicated across all bits).
    typedef struct {
        int   t;
        logic v;
    } d_evt_t;

    typedef struct {
        int   t;
        logic p;
        logic n;
        logic l;
    } samp_t;

    d_evt_t d_evts[13];
    samp_t  samps[14];

    // Random-run model state.
    logic [W-1:0] m_pos, m_neg, m_lat;
    logic [W-1:0] d_cur;
    logic         en_cur;

    initial begin
        d_evts = '{'{0, 1'b0}, '{7, 1'b1}, '{12, 1'b0}, '{14, 1'b1}, '{18, 1'b0},
                   '{21, 1'b1}, '{24, 1'b0}, '{26, 1'b1}, '{28, 1'b0}, '{32, 1'b1},
                   '{34, 1'b0}, '{36, 1'b1}, '{42, 1'b0}};
        samps  = '{'{1, 0, 0, 0}, '{6, 0, 0, 0}, '{11, 1, 0, 1}, '{13, 1, 0, 0},
                   '{15, 1, 0, 1}, '{19, 1, 0, 0}, '{25, 1, 0, 0}, '{31, 0, 0, 0},
                   '{33, 0, 0, 1}, '{35, 0, 0, 0}, '{37, 0, 0, 1}, '{41, 0, 1, 1},
                   '{45, 0, 1, 1}, '{51, 0, 1, 0}};

        rst_n = 1'b0;
        en    = 1'b1;
        d     = '0;

        // ---------------- waveform check ----------------
        fork
            begin
                #5 rst_n = 1'b1;
            end
            begin
                for (int i = 0; i < 13; i++) begin
                    #(d_evts[i].t - $time);
                    d = {W{d_evts[i].v}};
                end
            end
            begin
                for (int i = 0; i < 14; i++) begin
                    #(samps[i].t - $time);
                    chk3($sformatf("wave@%0d", samps[i].t),
                         {W{samps[i].p}}, {W{samps[i].n}}, {W{samps[i].l}});
                end
            end
        join

        // ---------------- glitch check ----------------
        @(negedge clk); #2 d = 8'h00;
        @(posedge clk); #2;
        @(negedge clk); #3 d = 8'hFF;
        #2 d = 8'h00;
        #2 chk3("glitch_low", 8'h00, 8'h00, 8'h00);
        @(posedge clk); #1 chk3("glitch_rise", 8'h00, 8'h00, 8'h00);

        // ---------------- async reset mid high phase ----------------
        @(negedge clk); #2 d = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk); #2 chk3("pre_reset_ones", 8'hFF, 8'hFF, 8'hFF);
        #1 rst_n = 1'b0;
        #0.5 chk3("async_reset_now", 8'h00, 8'h00, 8'h00);
        @(negedge clk); #1 chk3("reset_hold_fall", 8'h00, 8'h00, 8'h00);
        d = 8'h5A;

        // Release coincident with a rising edge: the NBA puts the release in
        // the same timestep, after the edge has sampled rst_n low.
        @(posedge clk);
        rst_n <= 1'b1;
        #1 chk3("release_on_rise", 8'h00, 8'h00, 8'h5A);
        @(negedge clk); #1 chk3("release_first_fall", 8'h00, 8'h5A, 8'h5A);
        @(posedge clk); #1 chk3("release_first_rise", 8'h5A, 8'h5A, 8'h5A);

        // ---------------- enable check ----------------
        @(negedge clk); #2 en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3 d = W'($urandom_range(0, 255));
            #3 chk3($sformatf("en_off_%0d", i), 8'h5A, 8'h5A, 8'h5A);
            @(clk);
        end
        #2 en = 1'b1; d = 8'hC3;
        if (clk) begin
            // en released while high: latch follows immediately.
            #1 chk3("en_on_high", 8'h5A, 8'h5A, 8'hC3);
            @(negedge clk); #1 chk3("en_on_fall", 8'h5A, 8'hC3, 8'hC3);
            @(posedge clk); #1 chk3("en_on_rise", 8'hC3, 8'hC3, 8'hC3);
        end else begin
            #1 chk3("en_on_low", 8'h5A, 8'h5A, 8'h5A);
            @(posedge clk); #1 chk3("en_on_rise", 8'hC3, 8'h5A, 8'hC3);
            @(negedge clk); #1 chk3("en_on_fall", 8'hC3, 8'hC3, 8'hC3);
        end

        // ---------------- width check ----------------
        @(negedge clk); #2 d = 8'hA5;
        @(posedge clk); #1 chk("width_lat_rise", q_lat, 8'hA5);
        #2 d = 8'h3C;
        #1 chk("width_lat_follow", q_lat, 8'h3C);
        @(negedge clk); #1 d = 8'h00;
        #2 chk3("width_low", 8'hA5, 8'h3C, 8'h3C);

        // ---------------- randomized run ----------------
        // Fresh reset in a low phase so the model starts from zero.
        @(negedge clk); #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        d_cur = W'($urandom_range(0, 255)); en_cur = 1'b1;
        d = d_cur; en = en_cur;
        m_pos = '0; m_neg = '0; m_lat = '0;
        #1 chk3("rand_start", m_pos, m_neg, m_lat);
        for (int i = 0; i < 200; i++) begin
            logic hi;
            logic [W-1:0] a, b;
            @(posedge clk or negedge clk);
            hi = clk;
            // Edge: the active flop (and the latch on a rise) takes the
            // d that was standing before the edge, if enabled.
            if (en_cur) begin
                if (hi) begin
                    m_pos = d_cur;
                    m_lat = d_cur;
                end else begin
                    m_neg = d_cur;
                end
            end
            a = W'($urandom);
            b = W'($urandom);
            #3;
            en_cur = ($urandom_range(0, 3) != 0);
            d_cur  = a;
            en = en_cur; d = d_cur;
            if (hi && en_cur) m_lat = d_cur;
            #2 chk3($sformatf("rand%0d_a", i), m_pos, m_neg, m_lat);
            #1;
            d_cur = b;
            d = d_cur;
            if (hi && en_cur) m_lat = d_cur;
            #2 chk3($sformatf("rand%0d_b", i), m_pos, m_neg, m_lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
